// File: rtl/ser8_pkg.sv
// Shared definitions for the ser8 transmitter: word/pointer widths, FSM
// state encoding and the alignment rotate used by both RTL and bench.
package ser8_pkg;
  localparam int WORD_W = 8;
  localparam int PTR_W  = 3;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Rotate left by p (0..7): upper byte of {w,w} << p.
  function automatic logic [WORD_W-1:0] rotl8(input logic [WORD_W-1:0] w,
                                              input logic [PTR_W-1:0]  p);
    logic [2*WORD_W-1:0] t;
    t = {w, w} << p;
    return t[2*WORD_W-1:WORD_W];
  endfunction
endpackage

// File: rtl/ser8_hold.sv
// One-entry holding register with valid/ready on the input side.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i   upstream handshake; ready = entry empty
//   pop_i             consumer takes the entry this edge
//   out_valid_o/out_data_o            entry state and contents
module ser8_hold
  import ser8_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              pop_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o
);
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;

  // Push only when empty and pop only when full, so both can never coincide.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = !valid_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
endmodule

// File: rtl/ser8_tx.sv
// 8:1 parallel-to-serial transmitter. Bytes arrive on a valid/ready
// handshake, are rotated by a CALIB-stepped alignment pointer when loaded
// into the shifter, and leave one bit per FCLK, gap-free when fed.
// Ports:
//   FCLK      bit clock          RESET     async active-high reset
//   CALIB     pointer +1 pulse   S_VALID/S_READY/S_DATA  word handshake
//   Q         serial bit         FRAME     Q carries bit slot 0
//   BUSY      word shifting      UNDERRUN  word ended with nothing held
module ser8_tx
  import ser8_pkg::*;
#(
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic       FCLK,
  input  logic       RESET,
  input  logic       CALIB,
  input  logic       S_VALID,
  output logic       S_READY,
  input  logic [7:0] S_DATA,
  output logic       Q,
  output logic       FRAME,
  output logic       BUSY,
  output logic       UNDERRUN
);
  state_t            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              q_q, q_d;
  logic              frame_q, frame_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic              hold_valid;
  logic [WORD_W-1:0] hold_data;
  logic              load;

  ser8_hold u_hold (
    .clk_i       (FCLK),
    .rst_i       (RESET),
    .in_valid_i  (S_VALID),
    .in_ready_o  (S_READY),
    .in_data_i   (S_DATA),
    .pop_i       (load),
    .out_valid_o (hold_valid),
    .out_data_o  (hold_data)
  );

  // Pointer only feeds the rotate at load time, so a CALIB on the load edge
  // still sees the old value and a word in flight is never re-aligned.
  assign ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, CALIB};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    q_d        = IDLE_BIT;
    frame_d    = 1'b0;
    busy_d     = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_valid) begin
          load     = 1'b1;
          bitcnt_d = 3'd0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        q_d      = MSB_FIRST ? shift_q[WORD_W-1] : shift_q[0];
        frame_d  = (bitcnt_q == 3'd0);
        busy_d   = 1'b1;
        shift_d  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        bitcnt_d = bitcnt_q + 3'd1;  // 7 -> 0 on back-to-back reload
        if (bitcnt_q == 3'd7) begin
          if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The last bit of the old word is taken from shift_q above before the
    // new word overwrites the shifter.
    if (load) shift_d = rotl8(hold_data, ptr_q);
  end

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= '0;
      ptr_q      <= '0;
      q_q        <= IDLE_BIT;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      q_q        <= q_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign Q        = q_q;
  assign FRAME    = frame_q;
  assign BUSY     = busy_q;
  assign UNDERRUN = underrun_q;
endmodule

// File: tb/tb_ser8_tx.sv
module tb_ser8_tx;
  import ser8_pkg::*;

  logic       FCLK, RESET, CALIB, S_VALID, S_READY, Q, FRAME, BUSY, UNDERRUN;
  logic [7:0] S_DATA;

  ser8_tx #(.MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .FCLK(FCLK), .RESET(RESET), .CALIB(CALIB), .S_VALID(S_VALID),
    .S_READY(S_READY), .S_DATA(S_DATA), .Q(Q), .FRAME(FRAME),
    .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  typedef struct { logic [7:0] data; logic [2:0] ptr; } src_t;
  typedef struct { logic q; logic frame; int slot; } exp_t;

  src_t src_q[$];
  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   acc_cnt = 0, mon_bits = 0;
  bit   rand_gap = 0, chk_ur = 1;
  logic [2:0] tptr = 3'd0;

  // Source: present queued words, optionally with random valid gaps.
  always @(negedge FCLK) begin
    if (!RESET && src_q.size() > 0 && (!rand_gap || $urandom_range(0, 1) == 1)) begin
      S_VALID = 1'b1;
      S_DATA  = src_q[0].data;
    end else begin
      S_VALID = 1'b0;
      S_DATA  = 8'($urandom);
    end
  end

  // Scoreboard push: on each handshake, expand the word into expected slots.
  always @(posedge FCLK) begin
    if (!RESET && S_VALID && S_READY && src_q.size() > 0) begin
      src_t s;
      logic [7:0] w;
      s = src_q.pop_front();
      w = rotl8(s.data, s.ptr);
      for (int n = 0; n < 8; n++) begin
        exp_t e;
        e.q = w[7-n];
        e.frame = (n == 0);
        e.slot = n;
        exp_q.push_back(e);
      end
      acc_cnt++;
    end
  end

  // Scoreboard pop/compare on every output cycle.
  always @(negedge FCLK) begin
    if (!RESET) begin
      if (BUSY) begin
        mon_bits++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_bit: got Q=%b FRAME=%b with nothing expected", Q, FRAME);
        end else begin
          exp_t e;
          logic ur;
          e = exp_q.pop_front();
          ur = (e.slot == 7) && (exp_q.size() == 0);
          if (Q !== e.q || FRAME !== e.frame || (chk_ur && UNDERRUN !== ur)) begin
            errors++;
            $display("FAIL bit slot=%0d: got Q=%b FRAME=%b UNDERRUN=%b want Q=%b FRAME=%b UNDERRUN=%b",
                     e.slot, Q, FRAME, UNDERRUN, e.q, e.frame, chk_ur ? ur : UNDERRUN);
          end
        end
      end else begin
        checks++;
        if (Q !== 1'b0 || FRAME !== 1'b0 || UNDERRUN !== 1'b0) begin
          errors++;
          $display("FAIL idle: got Q=%b FRAME=%b UNDERRUN=%b want 0 0 0", Q, FRAME, UNDERRUN);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] p);
    src_t s;
    s.data = d;
    s.ptr = p;
    src_q.push_back(s);
  endtask

  task automatic pulse_calib();
    @(negedge FCLK) CALIB = 1'b1;
    @(negedge FCLK) CALIB = 1'b0;
    tptr = tptr + 3'd1;
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge FCLK);
      #1;
      if (src_q.size() == 0 && exp_q.size() == 0 && !BUSY) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_accept(input int target, output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge FCLK);
      #1;
      if (acc_cnt >= target) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok, saw_busy;
    checks++;
    if (Q !== 1'b0 || FRAME !== 1'b0 || BUSY !== 1'b0 || UNDERRUN !== 1'b0 || S_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got Q=%b FRAME=%b BUSY=%b UR=%b RDY=%b want 0 0 0 0 1",
               Q, FRAME, BUSY, UNDERRUN, S_READY);
    end
    @(negedge FCLK) RESET = 1'b0;
    // Advance ptr to 1 so the mid-word reset also has to clear it.
    pulse_calib();
    send(8'hA5, tptr);
    send(8'hA5, tptr);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge FCLK);
      #1;
      if (FRAME) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_first_frame: got no FRAME want FRAME within 40 cycles"); end
    @(negedge FCLK);  // slot 1 of rotl(A5,1)=4B is 1, second word held
    #1;
    RESET = 1'b1;
    S_VALID = 1'b0;
    src_q.delete();
    exp_q.delete();
    #1;
    checks++;
    if (Q !== 1'b0 || BUSY !== 1'b0 || S_READY !== 1'b1 || FRAME !== 1'b0 || UNDERRUN !== 1'b0) begin
      errors++;
      $display("FAIL reset_midword: got Q=%b BUSY=%b RDY=%b FRAME=%b UR=%b want 0 0 1 0 0",
               Q, BUSY, S_READY, FRAME, UNDERRUN);
    end
    tptr = 3'd0;
    repeat (2) @(negedge FCLK);
    RESET = 1'b0;
    saw_busy = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge FCLK);
      if (BUSY || Q !== 1'b0) saw_busy = 1;
    end
    checks++;
    if (saw_busy) begin errors++; $display("FAIL reset_quiet: got bits after release want none"); end
  endtask

  task automatic test_single();
    bit ok;
    int a0;
    a0 = acc_cnt;
    send(8'hA5, tptr);
    wait_accept(a0 + 1, ok);  // now just after edge k
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got no handshake want one"); end
    @(negedge FCLK);
    checks++;
    if (BUSY !== 1'b0 || S_READY !== 1'b0) begin
      errors++;
      $display("FAIL single_k: got BUSY=%b RDY=%b want 0 0", BUSY, S_READY);
    end
    @(negedge FCLK);
    checks++;
    if (BUSY !== 1'b0 || Q !== 1'b0 || S_READY !== 1'b1) begin
      errors++;
      $display("FAIL single_k1: got BUSY=%b Q=%b RDY=%b want 0 0 1", BUSY, Q, S_READY);
    end
    @(negedge FCLK);
    checks++;
    if (FRAME !== 1'b1 || BUSY !== 1'b1 || Q !== 1'b1) begin
      errors++;
      $display("FAIL single_k2: got FRAME=%b BUSY=%b Q=%b want 1 1 1", FRAME, BUSY, Q);
    end
    repeat (7) @(negedge FCLK);
    checks++;
    if (UNDERRUN !== 1'b1 || BUSY !== 1'b1 || Q !== 1'b1) begin
      errors++;
      $display("FAIL single_k9: got UR=%b BUSY=%b Q=%b want 1 1 1", UNDERRUN, BUSY, Q);
    end
    @(negedge FCLK);
    checks++;
    if (BUSY !== 1'b0 || Q !== 1'b0 || UNDERRUN !== 1'b0) begin
      errors++;
      $display("FAIL single_k10: got BUSY=%b Q=%b UR=%b want 0 0 0", BUSY, Q, UNDERRUN);
    end
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_stream();
    bit ok, started;
    int busy_n, frame_n, frame_bad, ur_n;
    busy_n = 0; frame_n = 0; frame_bad = 0; ur_n = 0; started = 0;
    send(8'h01, tptr);
    send(8'hFF, tptr);
    send(8'h80, tptr);
    for (int c = 0; c < 120; c++) begin
      @(negedge FCLK);
      if (BUSY) begin
        started = 1;
        busy_n++;
        if (FRAME) begin
          frame_n++;
          if (busy_n % 8 != 1) frame_bad++;
        end
        if (UNDERRUN) begin
          ur_n++;
          if (busy_n != 24) frame_bad++;
        end
      end else if (started) break;
    end
    checks++;
    if (busy_n !== 24 || frame_n !== 3 || frame_bad !== 0 || ur_n !== 1) begin
      errors++;
      $display("FAIL stream: got run=%0d frames=%0d misplaced=%0d underruns=%0d want 24 3 0 1",
               busy_n, frame_n, frame_bad, ur_n);
    end
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_calib3();
    bit ok;
    repeat (3) pulse_calib();
    send(8'h01, tptr);  // rotl(01,3)=08 -> 0,0,0,0,1,0,0,0
    wait_drain(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL calib3_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_calib_on_load();
    bit ok;
    int a0;
    a0 = acc_cnt;
    send(8'h01, tptr);
    send(8'hF0, tptr);
    send(8'h01, tptr + 3'd1);
    wait_accept(a0 + 1, ok);  // edge k of word1; word2 loads at k+9
    checks++;
    if (!ok) begin errors++; $display("FAIL calibload_accept: got no handshake want one"); end
    repeat (8) @(posedge FCLK);
    @(negedge FCLK) CALIB = 1'b1;
    @(negedge FCLK) CALIB = 1'b0;
    tptr = tptr + 3'd1;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL calibload_drain: got %0d pending want 0", exp_q.size()); end
    // Complete eight pulses in total: pointer back to 0.
    repeat (4) pulse_calib();
    send(8'hA5, 3'd0);
    wait_drain(60, ok);
    checks++;
    if (!ok || tptr !== 3'd0) begin
      errors++;
      $display("FAIL calib8_drain: got pending=%0d ptr=%0d want 0 0", exp_q.size(), tptr);
    end
  endtask

  task automatic test_loopback();
    bit ok;
    logic bits [32];
    logic [7:0] w;
    int n, hits, hit_r, a0, b0;
    for (int t = 0; t < 8; t++) begin
      repeat (4) send(8'hA5, tptr);
      n = 0;
      for (int c = 0; c < 80 && n < 32; c++) begin
        @(negedge FCLK);
        if (BUSY) begin bits[n] = Q; n++; end
      end
      hits = 0; hit_r = -1;
      for (int r = 0; r < 8; r++) begin
        bit all = 1;
        for (int wi = 0; wi < 3; wi++) begin
          for (int b = 0; b < 8; b++) w[7-b] = bits[r + 8*wi + b];
          if (w !== 8'hA5) all = 0;
        end
        if (all) begin hits++; hit_r = r; end
      end
      checks++;
      if (n != 32 || hits != 1 || hit_r != (8 - t) % 8) begin
        errors++;
        $display("FAIL loopback tx_ptr=%0d: got bits=%0d hits=%0d rx_ptr=%0d want 32 1 %0d",
                 t, n, hits, hit_r, (8 - t) % 8);
      end
      wait_drain(60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL loopback_drain tx_ptr=%0d: got %0d pending want 0", t, exp_q.size()); end
      pulse_calib();
    end
    // Random valid gaps: underrun timing depends on the gaps, so only data is scored.
    rand_gap = 1; chk_ur = 0;
    a0 = acc_cnt; b0 = mon_bits;
    for (int i = 0; i < 16; i++) send(8'($urandom), tptr);
    wait_drain(2000, ok);
    checks++;
    if (!ok || acc_cnt - a0 != 16 || mon_bits - b0 != 128) begin
      errors++;
      $display("FAIL random_gaps: got words=%0d bits=%0d drained=%0d want 16 128 1",
               acc_cnt - a0, mon_bits - b0, ok);
    end
    rand_gap = 0; chk_ur = 1;
  endtask

  initial begin
    RESET = 1'b1; CALIB = 1'b0; S_VALID = 1'b0; S_DATA = 8'h00;
    repeat (3) @(negedge FCLK);
    #1;
    test_reset();
    test_single();
    test_stream();
    test_calib3();
    test_calib_on_load();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
